// File: rtl/dcmac_0_ts_ctx_accum.sv
// Per-channel signed context accumulator with read-modify-write through an
// external registered-read context memory; 2-cycle accept-to-result latency.
module dcmac_0_ts_ctx_accum #(
  parameter  int NUM_ID = 6,
  parameter  int DW     = 32,
  parameter  int SAT    = 1,
  localparam int ID_W   = (NUM_ID == 1) ? 1 : $clog2(NUM_ID)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_vld,
  output logic            o_rdy,
  input  logic [ID_W-1:0] i_id,
  input  logic [DW-1:0]   i_delta,
  input  logic            i_clr,
  output logic [ID_W-1:0] o_mem_rd_id,
  output logic            o_mem_ena,
  output logic [DW-1:0]   o_mem_dat,
  output logic            o_mem_rd_during_wr,
  input  logic [DW-1:0]   i_mem_dat,
  input  logic            i_mem_init,
  output logic            o_vld,
  output logic [ID_W-1:0] o_id,
  output logic [DW-1:0]   o_sum,
  output logic            o_ovf,
  output logic [15:0]     o_ovf_cnt
);

  logic [1:0]      guard_q;
  logic            accept;
  logic            p1_vld_q;
  logic [ID_W-1:0] p1_id_q;
  logic [DW-1:0]   p1_delta_q;
  logic            p1_clr_q;
  logic [DW:0]     sum_ext;
  logic            add_ovf;
  logic [DW-1:0]   new_d;
  logic            ovf_d;

  // Guard also covers the memory's trailing init write after i_mem_init drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      guard_q <= 2'd2;
    end else if (i_mem_init) begin
      guard_q <= 2'd2;
    end else if (guard_q != '0) begin
      guard_q <= guard_q - 2'd1;
    end
  end

  assign o_rdy  = (guard_q == '0) && !i_mem_init && !rst;
  assign accept = i_vld && o_rdy;

  assign o_mem_rd_id        = i_id;
  assign o_mem_rd_during_wr = accept && p1_vld_q && (i_id == p1_id_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld_q   <= 1'b0;
      p1_id_q    <= '0;
      p1_delta_q <= '0;
      p1_clr_q   <= 1'b0;
    end else begin
      p1_vld_q <= accept;
      if (accept) begin
        p1_id_q    <= i_id;
        p1_delta_q <= i_delta;
        p1_clr_q   <= i_clr;
      end
    end
  end

  assign sum_ext = {i_mem_dat[DW-1], i_mem_dat} + {p1_delta_q[DW-1], p1_delta_q};
  assign add_ovf = sum_ext[DW] ^ sum_ext[DW-1];

  always_comb begin
    new_d = sum_ext[DW-1:0];
    ovf_d = 1'b0;
    if (p1_clr_q) begin
      new_d = p1_delta_q;
    end else begin
      ovf_d = add_ovf;
      // Sign of the true (DW+1-bit) result selects the clamp direction.
      if (add_ovf && (SAT != 0)) begin
        new_d = sum_ext[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      end
    end
  end

  assign o_mem_ena = p1_vld_q;
  assign o_mem_dat = new_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vld     <= 1'b0;
      o_id      <= '0;
      o_sum     <= '0;
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
    end else begin
      o_vld <= p1_vld_q;
      o_ovf <= p1_vld_q && ovf_d;
      if (p1_vld_q) begin
        o_id  <= p1_id_q;
        o_sum <= new_d;
      end
      if (o_ovf && (o_ovf_cnt != '1)) begin
        o_ovf_cnt <= o_ovf_cnt + 16'd1;
      end
    end
  end

endmodule

// File: doc/dcmac_0_ts_ctx_accum.md
DCMAC_0_TS_CTX_ACCUM -- requirements
Module: dcmac_0_ts_ctx_accum

Interface
REQ-001 SHALL have parameter NUM_ID, default 6, number of channel contexts.
REQ-002 SHALL have parameter DW, default 32, context/accumulator width in bits, two's complement.
REQ-003 SHALL have parameter SAT, default 1, 1 = saturate on overflow, 0 = wrap.
REQ-004 SHALL derive localparam ID_W = 1 if NUM_ID==1, else clog2(NUM_ID).
REQ-005 SHALL have clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have i_vld  input  1  update request valid.
REQ-008 SHALL have o_rdy  output  1  request accepted when i_vld & o_rdy.
REQ-009 SHALL have i_id  input  ID_W  channel id, always < NUM_ID.
REQ-010 SHALL have i_delta  input  DW  signed increment.
REQ-011 SHALL have i_clr  input  1  replace context with i_delta instead of adding.
REQ-012 SHALL have o_mem_rd_id  output  ID_W  context memory read id.
REQ-013 SHALL have o_mem_ena  output  1  context memory write enable.
REQ-014 SHALL have o_mem_dat  output  DW  context memory write data.
REQ-015 SHALL have o_mem_rd_during_wr  output  1  memory forward-select (memory built with ENABLE_RD_DURING_WR=1).
REQ-016 SHALL have i_mem_dat  input  DW  memory read data, registered, valid one cycle after o_mem_rd_id.
REQ-017 SHALL have i_mem_init  input  1  memory initialisation in progress.
REQ-018 SHALL have o_vld, o_id[ID_W], o_sum[DW], o_ovf[1]  outputs  result valid, id, new context value, overflow flag.
REQ-019 SHALL have o_ovf_cnt  output  16  overflow event count.

Function
REQ-020 Memory contract: write of cycle N targets the id driven on o_mem_rd_id in cycle N-1; o_mem_ena in cycle N writes o_mem_dat at end of N.
REQ-021 o_mem_rd_id SHALL equal i_id combinationally every cycle.
REQ-022 Stage P0 (accept, cycle T): on i_vld & o_rdy register p1_vld=1, p1_id, p1_delta, p1_clr; else p1_vld=0.
REQ-023 Stage P1 (cycle T+1): cur = i_mem_dat; new = p1_clr ? p1_delta : cur + p1_delta; o_mem_ena = p1_vld; o_mem_dat = new.
REQ-024 Add SHALL use DW+1-bit signed sum; overflow = top two bits differ; SAT=1 clamps to 2^(DW-1)-1 or -2^(DW-1); SAT=0 keeps low DW bits; clear never overflows.
REQ-025 o_mem_rd_during_wr SHALL be high iff i_vld & o_rdy & p1_vld & (i_id == p1_id), so back-to-back same-id updates see the value written that cycle.
REQ-026 Output stage: o_vld, o_id, o_sum, o_ovf registered from P1 at end of T+1; latency accept-to-o_vld = 2 cycles; no output backpressure.
REQ-027 Throughput: one accepted request per cycle, any id sequence, including consecutive same id.
REQ-028 o_rdy SHALL be low while i_mem_init high and for 2 cycles after its falling edge (covers memory's trailing init write); high otherwise.
REQ-029 o_ovf_cnt SHALL increment on each o_ovf pulse, saturating at 0xFFFF.
REQ-030 Requests presented while o_rdy low SHALL be ignored; no memory write results.

Reset
REQ-031 rst high SHALL asynchronously clear p1_vld, o_vld, o_id, o_sum, o_ovf, o_ovf_cnt to 0 and force o_rdy=0.
REQ-032 After rst release o_rdy SHALL stay low until the i_mem_init guard of REQ-028 expires, even if i_mem_init is already low (guard counter resets to 2).
REQ-033 rst mid-pipeline SHALL drop in-flight updates; o_mem_ena=0 from rst assertion.

Verification
REQ-034 Reset, memory init NUM_ID=6 cycles, INIT_VALUE=0 -> o_rdy rises exactly 2 cycles after i_mem_init falls.
REQ-035 id=3 delta=5, then id=3 delta=7 back-to-back -> o_sum 5 then 12, o_mem_rd_during_wr=1 on 2nd, memory id3=12.
REQ-036 Interleaved id 0,1,0,1 deltas 1,2,3,4 -> o_sum 1,2,4,6 each 2 cycles after accept.
REQ-037 DW=32 SAT=1, context 0x7FFFFFF0, delta 0x20 -> o_sum 0x7FFFFFFF, o_ovf=1, o_ovf_cnt=1; SAT=0 -> 0x80000010.
REQ-038 id=2 context 100, i_clr=1 delta=-4 -> o_sum 0xFFFFFFFC, o_ovf=0.
REQ-039 rst asserted with 2 requests in flight -> no o_vld, no write, outputs 0, o_rdy 0 until guard expires.
